// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch (SS.hh) with start/stop, clear, lap hold and a
// sticky overflow flag; one count tick every DIV clocks while running.
module bcd_stopwatch #(
    parameter int DIV = 120000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3,
    output logic       running,
    output logic       ovf,
    output logic       held
);
    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_presc, w_presc_nxt;
    logic [3:0][3:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [3:0][3:0] r_hold, w_hold_nxt, w_disp;
    logic            r_ovf, w_ovf_nxt;
    logic            r_held, w_held_nxt;
    logic            w_tick, w_sat;

    assign w_tick = (r_state == S_RUN) && (r_presc == PMAX);
    assign w_sat  = (r_cnt == 16'h9999);

    // Ripple BCD increment; only used when the count is below 99.99.
    always_comb begin
        logic c;
        c         = 1'b1;
        w_cnt_inc = r_cnt;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r_cnt[i] == 4'd9) begin
                    w_cnt_inc[i] = 4'd0;
                end else begin
                    w_cnt_inc[i] = r_cnt[i] + 4'd1;
                    c            = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_held_nxt  = r_held;
        w_hold_nxt  = r_hold;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_presc_nxt = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_held_nxt  = 1'b0;
            w_hold_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_presc_nxt = '0;
                    if (start_stop) w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (w_tick) begin
                        w_presc_nxt = '0;
                        if (w_sat) begin
                            w_ovf_nxt   = 1'b1;
                            w_state_nxt = S_STOP;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                    if (start_stop) w_state_nxt = S_STOP;
                end
                S_STOP: begin
                    if (start_stop && !r_ovf) w_state_nxt = S_RUN;
                end
                default: w_state_nxt = S_IDLE;
            endcase
            // Hold captures the post-update count so a lap on a tick edge shows the new value.
            if (lap) begin
                if (r_state == S_RUN) begin
                    w_held_nxt = !r_held;
                    if (!r_held) w_hold_nxt = w_cnt_nxt;
                end else begin
                    w_held_nxt = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_ovf   <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
            r_ovf   <= w_ovf_nxt;
            r_held  <= w_held_nxt;
        end
    end

    assign w_disp  = r_held ? r_hold : r_cnt;
    assign bcd0    = w_disp[0];
    assign bcd1    = w_disp[1];
    assign bcd2    = w_disp[2];
    assign bcd3    = w_disp[3];
    assign running = (r_state == S_RUN);
    assign ovf     = r_ovf;
    assign held    = r_held;
endmodule

// File: doc/bcd_stopwatch.md
BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 Parameter DIV, default 120000: clock cycles per count tick (12 MHz / 120000 = 0.01 s); legal range 2..2^24.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start_stop  input  1  synchronous one-cycle pulse; toggles counting.
REQ-005 clear  input  1  synchronous one-cycle pulse; zeroes count, returns to IDLE.
REQ-006 lap  input  1  synchronous one-cycle pulse; toggles display hold.
REQ-007 bcd0  output  4  hundredths digit, 0..9, fed to a BCD-to-segment mapper.
REQ-008 bcd1  output  4  tenths digit, 0..9.
REQ-009 bcd2  output  4  seconds-units digit, 0..9.
REQ-010 bcd3  output  4  seconds-tens digit, 0..9.
REQ-011 running  output  1  high exactly while in state RUN.
REQ-012 ovf  output  1  sticky overflow flag.
REQ-013 held  output  1  high while display hold is active.

Function
REQ-014 States: IDLE, RUN, STOP; encoding is free.
- IDLE + start_stop -> RUN.
- RUN + start_stop -> STOP.
- STOP + start_stop -> RUN, unless ovf=1, in which case the state stays STOP.
- Any state + clear -> IDLE.
REQ-015 Prescaler, width ceil(log2(DIV)):
- Counts 0..DIV-1 only in RUN.
- tick=1 in the cycle where prescaler==DIV-1 and state is RUN; prescaler wraps to 0 on that edge.
REQ-016 Prescaler holds its value in STOP, so resume continues the partial period; it is zeroed in IDLE.
REQ-017 On a tick, the 4-digit count increments by one in BCD.
- Each digit wraps 9->0 with carry into the next digit.
- Non-BCD values (10..15) never occur in any digit.
REQ-018 Saturation: a tick when the count is 99.99 leaves the count at 99.99, sets ovf=1 and moves the state to STOP on the same edge.
REQ-019 ovf clears only on clear or reset.
REQ-020 start_stop and tick in the same cycle in RUN: the increment is applied and the state moves to STOP on the same edge.
REQ-021 clear has priority over start_stop, lap and tick in the same cycle.
- Count = 0, prescaler = 0, ovf = 0, held = 0, state = IDLE.
REQ-022 lap in RUN toggles held.
- held 0->1 captures the count as it stands after that edge's update into the hold register.
- While held=1, counting continues internally.
REQ-023 lap in IDLE or STOP forces held = 0.
REQ-024 Output mux: bcd3..bcd0 = hold register when held=1, otherwise the live count registers.
- The mux is combinational from registers only; there is no combinational path from any input to any output.
REQ-025 Latency: the live outputs change on the same clock edge at which tick is sampled high (1 cycle after prescaler reaches DIV-1).
- running, held and ovf change on the edge that samples the causing pulse.
REQ-026 start_stop, clear and lap arrive already synchronised and debounced; a pulse held high for N cycles counts as N pulses.

Reset
REQ-027 rst_n low asynchronously forces:
- state = IDLE; prescaler = 0; count = 00.00; hold register = 00.00.
- held = 0; ovf = 0; running = 0; bcd0..bcd3 = 0.
REQ-028 Reset asserted mid-run discards all progress; release resumes in IDLE with no spurious tick.

Verification (DIV=4 unless noted)
REQ-029 Reset, then start_stop pulse, 40 cycles:
- count reaches 00.10 (bcd1=1, bcd0=0); running=1.
- The digit carry 00.09->00.10 occurs on the 10th tick.
REQ-030 Run to 00.05, start_stop, idle 20 cycles, start_stop again:
- count holds 00.05 while stopped.
- The next tick arrives after the remaining prescaler cycles, not a full DIV.
REQ-031 Preload to 99.98 via runtime (DIV=2), let 2 ticks occur:
- count = 99.99, then ovf=1, running=0, count stays 99.99.
- A further start_stop leaves the state STOP.
- clear -> 00.00, ovf=0.
REQ-032 In RUN at 00.03, lap pulse:
- held=1, outputs frozen at 00.03 while internal count advances.
- Second lap -> outputs jump to the live count.
REQ-033 clear and start_stop in the same cycle while in RUN:
- next cycle IDLE, running=0, count 00.00.
- Separately, start_stop coincident with a tick -> count incremented and state STOP.
REQ-034 Assert rst_n low for 1 ns between clock edges mid-run: all outputs go to 0 immediately, with no clock edge required.
